ex_mem_pipe: RTL and testbench
==============================

# ex_mem_pipe

Parametrised EX/MEM pipeline register for the CPU datapath. It carries the four memory/writeback control bits, the ALU result, the store data and the destination register from EX to MEM. It adds a valid/ready handshake with a two-entry skid buffer, so `ex_ready` is a pure register output. It also adds a synchronous flush and an optional forwarding tap. It replaces the fixed-width, always-enabled EX/MEM latch.

## Interface
- `DATA_W`, 32: width of ALU result and store data.
- `RD_W`, 3: width of destination register index.

- `clk` in 1: clock, all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous kill of all held entries.
- `ex_valid` in 1: EX presents an instruction.
- `ex_ready` out 1: block accepts this cycle (registered).
- `ex_regwrite`, `ex_memtoreg`, `ex_memread`, `ex_memwrite` in 1 each: control bits.
- `ex_out` in DATA_W: ALU result / memory address.
- `ex_wdata` in DATA_W: store data.
- `ex_rd` in RD_W: destination register.
- `mem_valid` out 1: MEM-side entry valid.
- `mem_ready` in 1: MEM consumes the entry this cycle.
- `mem_regwrite`, `mem_memtoreg`, `mem_memread`, `mem_memwrite` out 1 each.
- `mem_out`, `mem_wdata` out DATA_W. `mem_rd` out RD_W.
- `fwd_hit` out 1, `fwd_rd` out RD_W, `fwd_data` out DATA_W: only with `EX_MEM_FWD_EN` defined.

## Operation
- Storage: main register (drives all `mem_*` outputs directly) plus one skid register. Each holds a valid bit and the full payload.
- Accept: `acc = ex_valid & ex_ready`. Drain: `drn = mem_valid & mem_ready`.
- State machine, encoded by valid bits:
  - EMPTY (main invalid, skid invalid): `acc` -> load main, go to ONE.
  - ONE (main valid, skid invalid):
    - `acc & drn` -> main <= input, stay in ONE.
    - `acc & !drn` -> skid <= input, go to TWO.
    - `!acc & drn` -> go to EMPTY.
    - Otherwise hold.
  - TWO (main valid, skid valid): `drn` -> main <= skid, go to ONE. Otherwise hold.
- `ex_ready` is 1 in EMPTY and ONE and 0 in TWO. It is registered, so `ex_ready` never depends combinationally on `mem_ready`.
- Flush has priority over every transition. On flush, both valid bits clear, and so do the main register's four control bits. The next state is EMPTY, and any input accepted in the same cycle is dropped.
- Whenever main is invalid, `mem_regwrite`/`mem_memtoreg`/`mem_memread`/`mem_memwrite` read 0. Data outputs hold their last value (don't-care).
- Ordering is strict FIFO, with no loss or duplication under any `ex_valid`/`mem_ready` pattern.
- Payload is passed bit-exact; no arithmetic.

## Timing
- Latency: accepted in cycle N, visible on `mem_*` after edge N+1 (one cycle), when main was empty or draining.
- Throughput: one instruction per cycle while `mem_ready`=1.
- Backpressure: `mem_ready` low for K cycles absorbs one extra entry. `ex_ready` falls the cycle after the skid fills and rises the cycle after the first drain from TWO.
- Reset (`rst_n`=0, asynchronous): `mem_valid`=0, all `mem_*` controls 0, `mem_out`/`mem_wdata`=0, `mem_rd`=0, `ex_ready`=1, skid cleared, `fwd_hit`=0. Reset mid-transfer discards both entries. First accept is possible on the first rising edge after `rst_n` deasserts.
- Simultaneous flush and `mem_ready`: the main entry counts as consumed this cycle, then everything clears.

## Configuration
- `EX_MEM_FWD_EN` defined:
  - `fwd_hit = mem_valid & mem_regwrite & !mem_memtoreg & (mem_rd != 0)`.
  - `fwd_rd = mem_rd`, `fwd_data = mem_out`.
  - Purely combinational from the main register, so it adds no latency.
- Not defined: the three `fwd_*` ports and their logic do not exist. All other behaviour is identical.

## Test plan
- Streaming:
  - Stimulus: `mem_ready`=1, four back-to-back accepts with `ex_out`=10, 20, 30, 40 and `ex_rd`=1..4.
  - Response: `mem_out` shows 10, 20, 30, 40 on consecutive cycles starting one cycle after the first accept; `ex_ready` stays 1.
- Backpressure:
  - Stimulus: accept A (`ex_out`=110, `ex_rd`=6), then B (`ex_out`=14) with `mem_ready`=0.
  - Response: `ex_ready`=0 the next cycle; A holds on the outputs. Raising `mem_ready` yields A then B, and `ex_ready` returns to 1.
- Flush:
  - Stimulus: state TWO with `mem_memwrite`=1 on the outputs; assert `flush` for one cycle together with `ex_valid`.
  - Response: `mem_valid`=0 and all controls 0 next cycle; the flushed input never appears.
- Async reset:
  - Stimulus: drop `rst_n` mid-cycle while `mem_valid`=1, `ex_out`=32'd40.
  - Response: outputs go to 0 immediately without a clock edge; `ex_ready`=1.
- Forwarding (`EX_MEM_FWD_EN`):
  - Stimulus: entry `regwrite`=1, `memtoreg`=0, `rd`=5, `out`=99.
  - Response: `fwd_hit`=1, `fwd_rd`=5, `fwd_data`=99.
  - Stimulus: same entry with `memtoreg`=1, or with `rd`=0.
  - Response: `fwd_hit`=0.
- Randomised valid/ready with 1000 transactions, checked against a scoreboard: in-order delivery, no drops, no duplicates.

Source files
------------

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register with a valid/ready handshake.
// It uses a main register and a one-entry skid register, a synchronous flush,
// and a registered ex_ready that never depends combinationally on mem_ready.
// Optional forwarding tap: define EX_MEM_FWD_EN to add the fwd_* ports.
module ex_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [DATA_W-1:0] ex_out,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [RD_W-1:0]   ex_rd,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_regwrite,
  output logic              mem_memtoreg,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [RD_W-1:0]   mem_rd
`ifdef EX_MEM_FWD_EN
  ,
  output logic              fwd_hit,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  // The state encoding matches the {skid valid, main valid} bit pair.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                r_exReady;
  logic [3:0]          r_mainCtrl;
  logic [DATA_W-1:0]   r_mainOut;
  logic [DATA_W-1:0]   r_mainWdata;
  logic [RD_W-1:0]     r_mainRd;
  logic [3:0]          r_skidCtrl;
  logic [DATA_W-1:0]   r_skidOut;
  logic [DATA_W-1:0]   r_skidWdata;
  logic [RD_W-1:0]     r_skidRd;
  logic [3:0]          w_inCtrl;
  logic                w_acc;
  logic                w_drn;
  logic                w_loadMainIn;
  logic                w_loadMainSkid;
  logic                w_loadSkid;

  assign w_inCtrl  = {ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite};
  assign mem_valid = (r_state != EMPTY);
  assign ex_ready  = r_exReady;
  assign w_acc     = ex_valid & r_exReady;
  assign w_drn     = mem_valid & mem_ready;

  // Next-state and load-enable decode; flush overrides every transition and drops the input.
  always_comb begin
    w_nextState    = r_state;
    w_loadMainIn   = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkid     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_loadMainIn = 1'b1;
          w_nextState  = ONE;
        end
      end
      ONE: begin
        if (w_acc && w_drn) begin
          w_loadMainIn = 1'b1;
        end else if (w_acc) begin
          w_loadSkid  = 1'b1;
          w_nextState = TWO;
        end else if (w_drn) begin
          w_nextState = EMPTY;
        end
      end
      TWO: begin
        if (w_drn) begin
          w_loadMainSkid = 1'b1;
          w_nextState    = ONE;
        end
      end
      default: w_nextState = EMPTY;
    endcase
    if (flush) begin
      w_nextState    = EMPTY;
      w_loadMainIn   = 1'b0;
      w_loadMainSkid = 1'b0;
      w_loadSkid     = 1'b0;
    end
  end

  // State register; ex_ready is precomputed from the next state so it is a pure flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_exReady <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_exReady <= (w_nextState != TWO);
    end
  end

  // Main register; control bits are cleared whenever main becomes empty, so idle reads as no-op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mainCtrl  <= '0;
      r_mainOut   <= '0;
      r_mainWdata <= '0;
      r_mainRd    <= '0;
    end else begin
      if (w_nextState == EMPTY) begin
        r_mainCtrl <= '0;
      end else if (w_loadMainIn) begin
        r_mainCtrl <= w_inCtrl;
      end else if (w_loadMainSkid) begin
        r_mainCtrl <= r_skidCtrl;
      end
      if (w_loadMainIn) begin
        r_mainOut   <= ex_out;
        r_mainWdata <= ex_wdata;
        r_mainRd    <= ex_rd;
      end else if (w_loadMainSkid) begin
        r_mainOut   <= r_skidOut;
        r_mainWdata <= r_skidWdata;
        r_mainRd    <= r_skidRd;
      end
    end
  end

  // Skid register captures the one entry that arrives while main is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skidCtrl  <= '0;
      r_skidOut   <= '0;
      r_skidWdata <= '0;
      r_skidRd    <= '0;
    end else if (w_loadSkid) begin
      r_skidCtrl  <= w_inCtrl;
      r_skidOut   <= ex_out;
      r_skidWdata <= ex_wdata;
      r_skidRd    <= ex_rd;
    end
  end

  assign mem_regwrite = r_mainCtrl[3];
  assign mem_memtoreg = r_mainCtrl[2];
  assign mem_memread  = r_mainCtrl[1];
  assign mem_memwrite = r_mainCtrl[0];
  assign mem_out      = r_mainOut;
  assign mem_wdata    = r_mainWdata;
  assign mem_rd       = r_mainRd;

`ifdef EX_MEM_FWD_EN
  // Forward only ALU results headed to a real register; loads are not ready yet in MEM.
  assign fwd_hit  = mem_valid & r_mainCtrl[3] & ~r_mainCtrl[2] & (r_mainRd != '0);
  assign fwd_rd   = r_mainRd;
  assign fwd_data = r_mainOut;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: table-driven vectors plus a FIFO scoreboard model for ex_mem_pipe.
module tb_ex_mem_pipe;

  localparam int DATA_W = 32;
  localparam int RD_W   = 3;

  typedef struct packed {
    logic [3:0]        ctrl;
    logic [DATA_W-1:0] out;
    logic [DATA_W-1:0] wdata;
    logic [RD_W-1:0]   rd;
  } payload_t;

  typedef struct {
    logic              v;
    logic              mr;
    logic [DATA_W-1:0] out;
    logic [RD_W-1:0]   rd;
    logic              expValid;
    logic              expReady;
    logic [DATA_W-1:0] expOut;
    logic [RD_W-1:0]   expRd;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              ex_valid;
  logic              ex_ready;
  logic              ex_regwrite;
  logic              ex_memtoreg;
  logic              ex_memread;
  logic              ex_memwrite;
  logic [DATA_W-1:0] ex_out;
  logic [DATA_W-1:0] ex_wdata;
  logic [RD_W-1:0]   ex_rd;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_regwrite;
  logic              mem_memtoreg;
  logic              mem_memread;
  logic              mem_memwrite;
  logic [DATA_W-1:0] mem_out;
  logic [DATA_W-1:0] mem_wdata;
  logic [RD_W-1:0]   mem_rd;
`ifdef EX_MEM_FWD_EN
  logic              fwd_hit;
  logic [RD_W-1:0]   fwd_rd;
  logic [DATA_W-1:0] fwd_data;
`endif

  int       testsRun    = 0;
  int       testsFailed = 0;
  int       popCount    = 0;
  payload_t model[$];
  vec_t     vecs[10];

  ex_mem_pipe #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_out(ex_out), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_out(mem_out), .mem_wdata(mem_wdata), .mem_rd(mem_rd)
`ifdef EX_MEM_FWD_EN
    , .fwd_hit(fwd_hit), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  // Free-running clock, rising edge active.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls the main sequence.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive one cycle, advance the FIFO model across the rising edge.
  task automatic applyStimulus(input logic v, input logic mr, input logic fl, input payload_t p);
    bit acc;
    bit drn;
    payload_t dropped;
    ex_valid    = v;
    mem_ready   = mr;
    flush       = fl;
    ex_regwrite = p.ctrl[3];
    ex_memtoreg = p.ctrl[2];
    ex_memread  = p.ctrl[1];
    ex_memwrite = p.ctrl[0];
    ex_out      = p.out;
    ex_wdata    = p.wdata;
    ex_rd       = p.rd;
    acc = v && (model.size() < 2);
    drn = (model.size() > 0) && mr;
    @(posedge clk);
    if (fl) begin
      model.delete();
    end else begin
      if (drn) begin
        dropped = model.pop_front();
        popCount++;
      end
      if (acc) model.push_back(p);
    end
    @(negedge clk);
  endtask

  // Compares DUT outputs with the head of the model queue.
  task automatic checkOutput(input string tag);
    payload_t head;
    check({tag, "_valid"}, 64'(mem_valid), 64'(model.size() != 0));
    check({tag, "_ready"}, 64'(ex_ready), 64'(model.size() < 2));
    if (model.size() != 0) begin
      head = model[0];
      check({tag, "_ctrl"}, 64'({mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite}), 64'(head.ctrl));
      check({tag, "_out"}, 64'(mem_out), 64'(head.out));
      check({tag, "_wdata"}, 64'(mem_wdata), 64'(head.wdata));
      check({tag, "_rd"}, 64'(mem_rd), 64'(head.rd));
    end else begin
      check({tag, "_ctrl_idle"}, 64'({mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite}), 64'(0));
    end
  endtask

  // Main test sequence.
  initial begin
    payload_t p;
    int cycles;
    rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
    ex_regwrite = 1'b0; ex_memtoreg = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_out = '0; ex_wdata = '0; ex_rd = '0;

    vecs[0] = '{1'b1, 1'b1, 32'd10,  3'd1, 1'b1, 1'b1, 32'd10,  3'd1};
    vecs[1] = '{1'b1, 1'b1, 32'd20,  3'd2, 1'b1, 1'b1, 32'd20,  3'd2};
    vecs[2] = '{1'b1, 1'b1, 32'd30,  3'd3, 1'b1, 1'b1, 32'd30,  3'd3};
    vecs[3] = '{1'b1, 1'b1, 32'd40,  3'd4, 1'b1, 1'b1, 32'd40,  3'd4};
    vecs[4] = '{1'b0, 1'b1, 32'd0,   3'd0, 1'b0, 1'b1, 32'd0,   3'd0};
    vecs[5] = '{1'b1, 1'b0, 32'd110, 3'd6, 1'b1, 1'b1, 32'd110, 3'd6};
    vecs[6] = '{1'b1, 1'b0, 32'd14,  3'd7, 1'b1, 1'b0, 32'd110, 3'd6};
    vecs[7] = '{1'b0, 1'b0, 32'd0,   3'd0, 1'b1, 1'b0, 32'd110, 3'd6};
    vecs[8] = '{1'b0, 1'b1, 32'd0,   3'd0, 1'b1, 1'b1, 32'd14,  3'd7};
    vecs[9] = '{1'b0, 1'b1, 32'd0,   3'd0, 1'b0, 1'b1, 32'd0,   3'd0};

    @(negedge clk);
    check("reset_valid", 64'(mem_valid), 64'(0));
    check("reset_ready", 64'(ex_ready), 64'(1));
    check("reset_ctrl", 64'({mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite}), 64'(0));
    check("reset_out", 64'(mem_out), 64'(0));
    check("reset_wdata", 64'(mem_wdata), 64'(0));
    check("reset_rd", 64'(mem_rd), 64'(0));
    #1 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      p = '{ctrl: 4'b1000, out: vecs[i].out, wdata: 32'h5A5A0000 + 32'(i), rd: vecs[i].rd};
      applyStimulus(vecs[i].v, vecs[i].mr, 1'b0, p);
      check($sformatf("vec%0d_valid", i), 64'(mem_valid), 64'(vecs[i].expValid));
      check($sformatf("vec%0d_ready", i), 64'(ex_ready), 64'(vecs[i].expReady));
      if (vecs[i].expValid) begin
        check($sformatf("vec%0d_out", i), 64'(mem_out), 64'(vecs[i].expOut));
        check($sformatf("vec%0d_rd", i), 64'(mem_rd), 64'(vecs[i].expRd));
      end
      checkOutput($sformatf("vec%0d_sb", i));
    end

    // Flush from TWO with a store on the outputs; the concurrent input is dropped.
    applyStimulus(1'b1, 1'b0, 1'b0, '{4'b0001, 32'h200, 32'hAAAA, 3'd2});
    applyStimulus(1'b1, 1'b0, 1'b0, '{4'b0001, 32'h201, 32'hBBBB, 3'd3});
    check("flush_pre_memwrite", 64'(mem_memwrite), 64'(1));
    check("flush_pre_ready", 64'(ex_ready), 64'(0));
    applyStimulus(1'b1, 1'b0, 1'b1, '{4'b1001, 32'h202, 32'hCCCC, 3'd4});
    check("flush_valid", 64'(mem_valid), 64'(0));
    check("flush_ctrl", 64'({mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite}), 64'(0));
    check("flush_ready", 64'(ex_ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      check($sformatf("flush_gone%0d", i), 64'(mem_valid), 64'(0));
      checkOutput("flush_sb");
    end

    // Flush together with mem_ready while holding one entry.
    applyStimulus(1'b1, 1'b0, 1'b0, '{4'b1000, 32'h300, 32'h1, 3'd1});
    applyStimulus(1'b0, 1'b1, 1'b1, '0);
    check("flush_drain_valid", 64'(mem_valid), 64'(0));
    checkOutput("flush_drain_sb");

    // Asynchronous reset in the middle of a cycle with a held entry.
    applyStimulus(1'b1, 1'b0, 1'b0, '{4'b1010, 32'd40, 32'h77, 3'd5});
    check("arst_pre_out", 64'(mem_out), 64'(40));
    ex_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(mem_valid), 64'(0));
    check("arst_ctrl", 64'({mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite}), 64'(0));
    check("arst_out", 64'(mem_out), 64'(0));
    check("arst_wdata", 64'(mem_wdata), 64'(0));
    check("arst_rd", 64'(mem_rd), 64'(0));
    check("arst_ready", 64'(ex_ready), 64'(1));
    model.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("arst_after");

`ifdef EX_MEM_FWD_EN
    check("fwd_idle", 64'(fwd_hit), 64'(0));
    applyStimulus(1'b1, 1'b0, 1'b0, '{4'b1000, 32'd99, 32'd0, 3'd5});
    check("fwd_hit", 64'(fwd_hit), 64'(1));
    check("fwd_rd", 64'(fwd_rd), 64'(5));
    check("fwd_data", 64'(fwd_data), 64'(99));
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '{4'b1100, 32'd99, 32'd0, 3'd5});
    check("fwd_memtoreg", 64'(fwd_hit), 64'(0));
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '{4'b1000, 32'd99, 32'd0, 3'd0});
    check("fwd_rd0", 64'(fwd_hit), 64'(0));
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
`endif

    // Random valid/ready until 1000 entries are delivered, each cycle checked against the model.
    popCount = 0;
    cycles   = 0;
    while (popCount < 1000 && cycles < 20000) begin
      checkOutput("rand");
      p.ctrl  = 4'($urandom);
      p.out   = 32'(cycles);
      p.wdata = $urandom;
      p.rd    = 3'($urandom);
      applyStimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), 1'b0, p);
      cycles++;
    end
    check("rand_delivered", 64'(popCount >= 1000), 64'(1));
    checkOutput("rand_final");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
